apb_fifo_slave: RTL
===================

// Module: apb_fifo_slave
// PURPOSE
//  APB3 completer bridging the APB bus to two 32-bit streaming FIFOs, sitting as a slave on one PSELx of APB_Master.
//  TX path: APB writes push into TX FIFO, drained by a valid/ready stream. RX path: stream pushes into RX FIFO, popped by APB reads.
//  Inserts wait states (PREADY low) while the target FIFO is full/empty, exercising the master's wait handling.
// PARAMETERS
//  DEPTH    8   entries per FIFO; power of two, 2..128
//  TIMEOUT  16  max stall cycles before error completion (only with APB_FIFO_SLVERR_EN)
// PORTS
//  PCLK      in   1   clock; all state on rising edge
//  PRESETn   in   1   asynchronous active-low reset
//  PADDR     in   4   byte address; [3:2] selects register, [1:0] ignored
//  PWRITE    in   1   1=write, 0=read
//  PENABLE   in   1   APB access phase
//  PWDATA    in   32  write data
//  PSEL      in   1   slave select
//  PRDATA    out  32  read data, valid when PSEL&PENABLE&PREADY
//  PREADY    out  1   transfer complete
//  PSLVERR   out  1   error response (port exists only with APB_FIFO_SLVERR_EN)
//  tx_data   out  32  TX FIFO head
//  tx_valid  out  1   TX FIFO non-empty
//  tx_ready  in   1   downstream accepts tx_data
//  rx_data   in   32  upstream data
//  rx_valid  in   1   upstream data valid
//  rx_ready  out  1   RX FIFO not full
// BEHAVIOUR
//  Reset: both FIFOs empty, counters 0, FSM IDLE; PRDATA=0, PREADY=0, PSLVERR=0, tx_valid=0, rx_ready=1.
//  Register map: 0x0 TXDATA (W push; R returns 0); 0x4 RXDATA (R pop; W ignored, no error);
//   0x8 STATUS (RO): [0]tx_full [1]tx_empty [2]rx_full [3]rx_empty [15:8]tx_count [23:16]rx_count, rest 0;
//   0xC CTRL (W): [0]tx_flush [1]rx_flush, self-clearing, read as 0.
//  FSM IDLE->SETUP on PSEL&!PENABLE; SETUP->ACCESS; ACCESS->IDLE when PREADY=1, else stay.
//  stall = ACCESS & ((write TXDATA & tx_full) | (read RXDATA & rx_empty)).
//  PREADY = ACCESS & !stall (combinational); zero-wait access completes in the first PENABLE cycle.
//  Side effects (push, pop, flush) occur only on the completing edge (PSEL&PENABLE&PREADY).
//  PRDATA driven combinationally in ACCESS: RXDATA -> RX head (show-ahead), STATUS live value; 0 otherwise.
//  TX stream: pop on tx_valid&tx_ready. RX stream: push on rx_valid&rx_ready.
//  Count width $clog2(DEPTH)+1; pointers wrap modulo DEPTH; full at count==DEPTH.
//  Simultaneous: stall is evaluated on state at cycle start. A stream pop of a full TX FIFO frees space, and the APB push completes the next cycle.
//   APB pop + rx push in one cycle: both happen, rx_count unchanged. Flush beats same-cycle stream push/pop.
//  PSEL dropped mid-ACCESS: FSM returns to IDLE, no side effect, stall counter cleared.
//  Async reset mid-transfer: all state cleared immediately, PREADY=0.
// CONFIGURATION
//  APB_FIFO_SLVERR_EN defined: stall counter increments each stalled ACCESS cycle.
//   At count==TIMEOUT: PREADY=1, PSLVERR=1, no push/pop, counter cleared. PSLVERR=0 on all other completions.
//  Not defined: no PSLVERR port, no counter; PREADY stays low indefinitely until the FIFO condition clears.
// TESTING
//  1 Write 0x0 data 1,2,3 with tx_ready=0 -> each completes zero-wait; STATUS read = 0x0000_0308 (tx_count=3, rx_empty).
//  2 tx_ready=1 after 1 -> tx_data 1,2,3 in order on consecutive cycles; tx_valid drops after third; tx_empty=1.
//  3 Fill TX (8 writes), 9th write -> PREADY low; pulse tx_ready for one cycle -> 9th completes next cycle, tx_count=8.
//  4 Drive rx_data 0xA5 with rx_valid one cycle, read 0x4 -> PRDATA=0xA5, zero-wait; rx_empty=1 afterwards.
//  5 Read 0x4 with RX empty, SLVERR_EN, TIMEOUT=16 -> 16 wait cycles then PREADY=1, PSLVERR=1; rx_count still 0.
//  6 TX holds 5 entries, write 0xC = 0x1 -> tx_count=0, tx_valid=0 next cycle; PRESETn low mid-ACCESS -> PREADY=0 immediately.

Source files
------------

// File: rtl/apb_fifo_slave_if.sv
// APB3 signal bundle between an APB requester and apb_fifo_slave.
// PSLVERR exists only when APB_FIFO_SLVERR_EN is defined.
interface apb_fifo_slave_if;
  logic [3:0]  PADDR;
  logic        PWRITE;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic        PSEL;
  logic [31:0] PRDATA;
  logic        PREADY;
`ifdef APB_FIFO_SLVERR_EN
  logic        PSLVERR;
`endif

  modport master (
    output PADDR, PWRITE, PENABLE, PWDATA, PSEL,
    input  PRDATA, PREADY
`ifdef APB_FIFO_SLVERR_EN
    , input PSLVERR
`endif
  );

  modport slave (
    input  PADDR, PWRITE, PENABLE, PWDATA, PSEL,
    output PRDATA, PREADY
`ifdef APB_FIFO_SLVERR_EN
    , output PSLVERR
`endif
  );
endinterface

// File: rtl/apb_fifo_slave.sv
// APB3 completer bridging the bus to a TX stream FIFO (APB writes, stream drains)
// and an RX stream FIFO (stream fills, APB reads). Wait states are inserted
// while the addressed FIFO is full (TX write) or empty (RX read).
// Optional feature macro: APB_FIFO_SLVERR_EN adds PSLVERR and a stall timeout
// that completes a stalled access with an error after TIMEOUT wait cycles.
module apb_fifo_slave #(
  parameter int unsigned DEPTH = 8
`ifdef APB_FIFO_SLVERR_EN
  ,
  parameter int unsigned TIMEOUT = 16
`endif
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_fifo_slave_if.slave  apb,
  output logic [31:0]      tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [31:0]      rx_data,
  input  logic             rx_valid,
  output logic             rx_ready
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // SETUP: setup phase was captured, bus now sits in its first access cycle.
  // ACCESS: access phase extended by wait states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state;

  logic [31:0]      tx_mem [DEPTH];
  logic [31:0]      rx_mem [DEPTH];
  logic [PTR_W-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [CNT_W-1:0] tx_count, rx_count;

  logic [1:0]  reg_sel;
  logic        access, stall, xfer;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push, tx_pop, tx_flush;
  logic        rx_push, rx_pop, rx_flush;
  logic [31:0] status;
  logic [31:0] prdata;
  logic        unused_paddr_bits;

  assign reg_sel           = apb.PADDR[3:2];
  assign unused_paddr_bits = ^apb.PADDR[1:0];

  assign tx_full  = (tx_count == CNT_W'(DEPTH));
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == CNT_W'(DEPTH));
  assign rx_empty = (rx_count == '0);

  assign access = (state != IDLE) & apb.PSEL & apb.PENABLE;
  assign stall  = access &
                  (( apb.PWRITE & (reg_sel == REG_TXDATA) & tx_full) |
                   (~apb.PWRITE & (reg_sel == REG_RXDATA) & rx_empty));

  // Side effects only on a normal (non-stalled) completion.
  assign xfer     = access & ~stall;
  assign tx_push  = xfer &  apb.PWRITE & (reg_sel == REG_TXDATA);
  assign rx_pop   = xfer & ~apb.PWRITE & (reg_sel == REG_RXDATA);
  assign tx_flush = xfer &  apb.PWRITE & (reg_sel == REG_CTRL) & apb.PWDATA[0];
  assign rx_flush = xfer &  apb.PWRITE & (reg_sel == REG_CTRL) & apb.PWDATA[1];

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_mem[tx_rd_ptr];
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_ready = ~rx_full;
  assign rx_push  = rx_valid & rx_ready;

`ifdef APB_FIFO_SLVERR_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);

  logic [STALL_W-1:0] stall_cnt;
  logic               timeout;

  assign timeout     = stall & (stall_cnt == STALL_W'(TIMEOUT));
  assign apb.PREADY  = access & (~stall | timeout);
  assign apb.PSLVERR = timeout;

  // Count consecutive stalled access cycles; cleared on completion or abort.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      stall_cnt <= '0;
    end else if (!access || apb.PREADY) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end
`else
  assign apb.PREADY = access & ~stall;
`endif

  // APB phase tracking; PSEL dropped mid-access returns to IDLE.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (apb.PSEL && !apb.PENABLE) state <= SETUP;
        end
        SETUP, ACCESS: begin
          if (!apb.PSEL || apb.PREADY) state <= IDLE;
          else if (!apb.PENABLE)       state <= SETUP;
          else                         state <= ACCESS;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign status = {8'h00, 8'(rx_count), 8'(tx_count), 4'h0,
                   rx_empty, rx_full, tx_empty, tx_full};

  // Read data mux: show-ahead RX head or live status during read access.
  always_comb begin
    prdata = '0;
    if (access && !apb.PWRITE) begin
      case (reg_sel)
        REG_RXDATA: prdata = rx_mem[rx_rd_ptr];
        REG_STATUS: prdata = status;
        default:    prdata = '0;
      endcase
    end
  end

  assign apb.PRDATA = prdata;

  // TX FIFO pointers and occupancy; flush overrides same-cycle push/pop.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else if (tx_flush) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + CNT_W'(1);
      else if (!tx_push && tx_pop) tx_count <= tx_count - CNT_W'(1);
    end
  end

  // TX FIFO storage.
  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= apb.PWDATA;
  end

  // RX FIFO pointers and occupancy; flush overrides same-cycle push/pop.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else if (rx_flush) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + CNT_W'(1);
      else if (!rx_push && rx_pop) rx_count <= rx_count - CNT_W'(1);
    end
  end

  // RX FIFO storage.
  always_ff @(posedge PCLK) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end
endmodule
